// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: core-side request/response and memory-side bus
// signals of the unified memory arbiter.
// slave  : arbiter view (serves IF/DM requests, drives the memory port)
// master : environment view (requesters and memory)
interface unified_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          if_err;

    logic          dm_req;
    logic          dm_we;
    logic [2:0]    dm_fn3;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          dm_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          core_stall;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata, if_err,
        input  dm_req, dm_we, dm_fn3, dm_addr, dm_wdata,
        output dm_ack, dm_rdata, dm_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata,
        output core_stall
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata, if_err,
        output dm_req, dm_we, dm_fn3, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata, dm_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata,
        input  core_stall
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one unified memory port between instruction
// fetch (IF) and load/store (DM). DM has fixed priority; a starvation counter
// forces an IF grant after STARVE_LIM consecutive lost arbitrations. Handles
// store byte-lane steering, load sign/zero extension and misaligned/illegal
// access detection.
// Optional: define ARB_TIMEOUT_EN to abort a memory access after TIMEOUT
// wait cycles without mem_ack.
module unified_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ERR} state_t;

    localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] starve_cnt;
    logic          err_dm;
    logic [1:0]    lat_off;
    logic [2:0]    lat_fn3;
    logic          lat_we;

    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [DW-1:0] mem_wdata_q;

    logic          starve_hit;
    logic          dm_win;
    logic          if_win;
    logic          dm_illegal;
    logic          dm_misal;
    logic          dm_bad;
    logic          if_misal;
    logic          busy;
    logic          timeout_hit;
    logic [3:0]    st_be;
    logic [DW-1:0] st_wdata;
    logic [DW-1:0] lane;
    logic [DW-1:0] load_ext;

    assign busy       = (state == BUSY_IF) || (state == BUSY_DM);
    assign starve_hit = bus.if_req && (starve_cnt == SW'(STARVE_LIM));
    assign dm_win     = bus.dm_req && !starve_hit;
    assign if_win     = bus.if_req && !dm_win;
    assign if_misal   = (bus.if_addr[1:0] != 2'b00);
    assign dm_bad     = dm_illegal || dm_misal;

    // DM legality: opcode size/sign code and natural alignment
    always_comb begin
        dm_illegal = 1'b1;
        case (bus.dm_fn3)
            3'b000, 3'b001, 3'b010: dm_illegal = 1'b0;
            3'b100, 3'b101:         dm_illegal = bus.dm_we;
            default:                dm_illegal = 1'b1;
        endcase
        dm_misal = ((bus.dm_fn3[1:0] == 2'b01) && bus.dm_addr[0]) ||
                   ((bus.dm_fn3[1:0] == 2'b10) && (bus.dm_addr[1:0] != 2'b00));
    end

    // Store lane steering: replicate narrow data to all lanes, enable selected lanes
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = bus.dm_wdata;
        case (bus.dm_fn3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << bus.dm_addr[1:0];
                st_wdata = {4{bus.dm_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << bus.dm_addr[1:0];
                st_wdata = {2{bus.dm_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.dm_wdata;
            end
        endcase
    end

    // Load extraction: pick the addressed lane and extend per size/sign code
    always_comb begin
        lane = bus.mem_rdata >> {lat_off, 3'b000};
        case (lat_fn3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h000000, lane[7:0]};
            3'b101:  load_ext = {16'h0000, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    // Count BUSY cycles without mem_ack; cleared while IDLE so each access starts at 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!busy) begin
            wait_cnt <= '0;
        end else if (!bus.mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = busy && !bus.mem_ack && (wait_cnt == TW'(TIMEOUT - 1));
`else
    // No abort: BUSY waits indefinitely (TIMEOUT is never negative)
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and requester-side responses
    always_comb begin
        state_nx     = state;
        bus.if_ack   = 1'b0;
        bus.if_err   = 1'b0;
        bus.if_rdata = '0;
        bus.dm_ack   = 1'b0;
        bus.dm_err   = 1'b0;
        bus.dm_rdata = '0;
        case (state)
            IDLE: begin
                if (dm_win) begin
                    state_nx = dm_bad ? ERR : BUSY_DM;
                end else if (if_win) begin
                    state_nx = if_misal ? ERR : BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    state_nx     = IDLE;
                    bus.if_ack   = 1'b1;
                    bus.if_rdata = bus.mem_rdata;
                end else if (timeout_hit) begin
                    state_nx = ERR;
                end
            end
            BUSY_DM: begin
                if (bus.mem_ack) begin
                    state_nx     = IDLE;
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = lat_we ? '0 : load_ext;
                end else if (timeout_hit) begin
                    state_nx = ERR;
                end
            end
            ERR: begin
                state_nx   = IDLE;
                bus.dm_ack = err_dm;
                bus.dm_err = err_dm;
                bus.if_ack = !err_dm;
                bus.if_err = !err_dm;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Arbitration bookkeeping: starvation counter and latched request attributes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            err_dm     <= 1'b0;
            lat_off    <= 2'b00;
            lat_fn3    <= 3'b000;
            lat_we     <= 1'b0;
        end else if (state == IDLE) begin
            if (if_win) begin
                starve_cnt <= '0;
                err_dm     <= 1'b0;
            end else if (dm_win) begin
                if (bus.if_req && (starve_cnt != SW'(STARVE_LIM))) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
                err_dm  <= 1'b1;
                lat_off <= bus.dm_addr[1:0];
                lat_fn3 <= bus.dm_fn3;
                lat_we  <= bus.dm_we;
            end
        end
    end

    // Registered memory port: loaded on a legal grant, request held until completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
        end else if (state == IDLE) begin
            if (dm_win && !dm_bad) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.dm_we;
                mem_addr_q  <= {bus.dm_addr[AW-1:2], 2'b00};
                mem_be_q    <= bus.dm_we ? st_be : 4'b1111;
                mem_wdata_q <= bus.dm_we ? st_wdata : '0;
            end else if (if_win && !if_misal) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= {bus.if_addr[AW-1:2], 2'b00};
                mem_be_q    <= 4'b1111;
                mem_wdata_q <= '0;
            end
        end else if (busy && (bus.mem_ack || timeout_hit)) begin
            mem_req_q <= 1'b0;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_stall = reset && ((bus.if_req && !bus.if_ack) ||
                                      (bus.dm_req && !bus.dm_ack));

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one unified instruction/data memory port between two requesters: the instruction-fetch path (IF) and the load/store path (DM).
- Sits between the core and the memory. Handles arbitration, byte-lane steering for stores, load extraction with sign/zero extension, misalignment detection, and a core stall signal.
- Priority is fixed, DM over IF. A starvation counter guarantees IF progress.

Parameters:
AW, 32, address width
DW, 32, data width (fixed 32; byte lanes assume 4)
STARVE_LIM, 2, consecutive lost IF arbitrations before IF is forced to win
TIMEOUT, 15, memory wait cycles before abort (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
if_req  in  1  fetch request, held until if_ack
if_addr  in  AW  fetch byte address; must be word aligned
if_ack  out  1  fetch complete (comb, one cycle)
if_rdata  out  DW  fetched word, valid with if_ack
if_err  out  1  fetch error (misaligned or timeout), valid with if_ack
dm_req  in  1  load/store request, held with attributes until dm_ack
dm_we  in  1  1=store, 0=load
dm_fn3  in  3  funct3 size/sign code
dm_addr  in  AW  byte address
dm_wdata  in  DW  store data, right-justified
dm_ack  out  1  load/store complete (one cycle)
dm_rdata  out  DW  extended load data, valid with dm_ack
dm_err  out  1  misaligned/illegal/timeout, valid with dm_ack
mem_req  out  1  memory request (registered)
mem_we  out  1  write enable (registered)
mem_addr  out  AW  word-aligned address {addr[AW-1:2],2'b00} (registered)
mem_be  out  4  byte enables (registered)
mem_wdata  out  DW  lane-steered store data (registered)
mem_ack  in  1  memory completes current access this cycle
mem_rdata  in  DW  read word, valid with mem_ack
core_stall  out  1  (if_req&~if_ack)|(dm_req&~dm_ack)

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM, ERR.
- Reset, asynchronous: state=IDLE; mem_req/mem_we/mem_be/mem_addr/mem_wdata=0; starvation counter=0. All acks/errs are 0 and data outputs are 0 while in reset. An in-flight memory access is abandoned.
- IDLE, winner selection:
  - DM wins if dm_req and not (if_req and starve_cnt==STARVE_LIM); otherwise IF wins if if_req.
  - Counter: +1 when both requests are present and DM wins; cleared when IF wins; saturates at STARVE_LIM.
- IDLE, legality check on the winner:
  - DM legal fn3: loads 000/001/010/100/101; stores 000/001/010. Any other fn3 is illegal.
  - DM misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - IF misaligned: if_addr[1:0]!=0.
  - An illegal or misaligned winner moves to ERR with no memory access.
- IDLE, legal winner: latch mem_* and move to BUSY_x. mem_req rises on the next cycle.
- Store lane steering (off = addr[1:0]):
  - SB: be=0001<<off, wdata byte replicated to all 4 lanes.
  - SH: be=0011<<off, halfword replicated in both halves.
  - SW: be=1111.
  - Loads and fetches: be=1111, we=0.
- BUSY_x: mem_req held until mem_ack. In the mem_ack cycle, x_ack=1 (combinational), then return to IDLE at the clock edge.
  - Load extraction: lane selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Zero-wait memory: request cycle 0 → mem_req cycle 1 → x_ack cycle 1. A held request is re-arbitrated at cycle 2.
- ERR: one cycle; x_ack=1, x_err=1, x_rdata=0. Then IDLE.
- Requester rules: req, addr, fn3 and wdata stable while req=1 and ack=0. A requester sampling ack=1 may keep req high for a new access. Dropping req before ack is illegal (bench assertion).
- Both requesters are never acked in the same cycle.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a wait counter clears on entry to BUSY_x and increments each BUSY cycle without mem_ack. At TIMEOUT, mem_req drops, the arbiter enters ERR for that requester (x_ack=1, x_err=1), and a late mem_ack is ignored.
- Undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Reset mid-access: assert reset=0 during BUSY_DM → mem_req=0 the same cycle, all outputs 0; after release, IDLE and counter=0.
- IF only, zero-wait memory: if_addr=0x100, mem_rdata=0x00500093 → mem_addr=0x100, be=1111, if_ack with if_rdata=0x00500093 on cycle 1.
- LB sign-extend: dm_addr=0x203, fn3=000, mem_rdata=0x80FF_1234 → dm_rdata=0xFFFF_FF80. Same access with LBU (fn3=100) → 0x0000_0080.
- SH lane steering: dm_addr=0x12, wdata=0xABCD_BEEF → mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x10.
- Misaligned SW: addr=0x21 → no mem_req; dm_ack=1 and dm_err=1 one cycle after the request.
- Starvation, STARVE_LIM=2, both requests continuously held: grant order DM, DM, IF, DM, DM, IF. core_stall=1 whenever a held request is unacked.
